// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/writeback,
// traps on illegal opcodes and counts retired instructions.
module multicycle_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] opcode_onehot,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_re,
    output logic        ir_en,
    output logic        pc_en,
    output logic        pc_load,
    output logic        br_eval,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        reg_we,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6,
        StBad    = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        ClsNone   = 3'd0,
        ClsAlu    = 3'd1,
        ClsLoad   = 3'd2,
        ClsStore  = 3'd3,
        ClsBranch = 3'd4,
        ClsJump   = 3'd5,
        ClsJal    = 3'd6
    } class_e;

    // Opcode-decoder bit positions belonging to each instruction class.
    localparam logic [31:0] AluMask    = 32'h0020_0021;
    localparam logic [31:0] LoadMask   = 32'h0000_0100;
    localparam logic [31:0] StoreMask  = 32'h0000_0080;
    localparam logic [31:0] BranchMask = 32'h0000_0044;
    localparam logic [31:0] JumpMask   = 32'h0000_0012;
    localparam logic [31:0] JalMask    = 32'h0000_0008;

    state_e      state_q, state_d;
    class_e      class_q, class_d;
    logic        illegal_q, illegal_d;
    logic [15:0] retired_q, retired_d;

    class_e      dec_class;
    logic        is_onehot;
    logic        complete;
    state_e      next_fetch;

    // Classify the decoder output; anything not exactly one known bit is illegal.
    always_comb begin
        is_onehot = (opcode_onehot != 32'd0) &&
                    ((opcode_onehot & (opcode_onehot - 32'd1)) == 32'd0);
        dec_class = ClsNone;
        if (is_onehot) begin
            if      ((opcode_onehot & AluMask)    != 32'd0) dec_class = ClsAlu;
            else if ((opcode_onehot & LoadMask)   != 32'd0) dec_class = ClsLoad;
            else if ((opcode_onehot & StoreMask)  != 32'd0) dec_class = ClsStore;
            else if ((opcode_onehot & BranchMask) != 32'd0) dec_class = ClsBranch;
            else if ((opcode_onehot & JumpMask)   != 32'd0) dec_class = ClsJump;
            else if ((opcode_onehot & JalMask)    != 32'd0) dec_class = ClsJal;
            else                                             dec_class = ClsNone;
        end
    end

    // Next-state, class, trap flag and retire counter.
    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        illegal_d  = illegal_q;
        retired_d  = retired_q;
        complete   = 1'b0;
        // run only matters when an instruction completes (or from IDLE).
        next_fetch = run ? StFetch : StIdle;

        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (imem_ready) state_d = StDecode;
            end
            StDecode: begin
                class_d = dec_class;
                if (dec_class == ClsNone) begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (class_q)
                    ClsAlu, ClsJal:     state_d = StWb;
                    ClsLoad, ClsStore:  state_d = StMem;
                    ClsBranch, ClsJump: begin
                        state_d  = next_fetch;
                        complete = 1'b1;
                    end
                    default: begin
                        state_d   = StTrap;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMem: begin
                if (dmem_ready) begin
                    if (class_q == ClsLoad) begin
                        state_d = StWb;
                    end else begin
                        state_d  = next_fetch;
                        complete = 1'b1;
                    end
                end
            end
            StWb: begin
                state_d  = next_fetch;
                complete = 1'b1;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (complete) retired_d = retired_q + 16'd1;
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            class_q   <= ClsNone;
            illegal_q <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Datapath strobes decoded from state, class and ready inputs only.
    always_comb begin
        imem_re = 1'b0;
        ir_en   = 1'b0;
        pc_en   = 1'b0;
        pc_load = 1'b0;
        br_eval = 1'b0;
        dmem_re = 1'b0;
        dmem_we = 1'b0;
        reg_we  = 1'b0;
        case (state_q)
            StFetch: begin
                imem_re = 1'b1;
                ir_en   = imem_ready;
                pc_en   = imem_ready;
            end
            StExec: begin
                br_eval = (class_q == ClsBranch);
                pc_load = (class_q == ClsJump) || (class_q == ClsJal);
            end
            StMem: begin
                dmem_re = (class_q == ClsLoad);
                dmem_we = (class_q == ClsStore);
            end
            StWb: begin
                reg_we = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule
